// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_pkg
//  Description : Shared constants for the CP0 / exception unit: CP0 register
//                numbers, exception codes, Status bit positions, instruction
//                encodings and FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cp0_pkg;

    // CP0 register numbers (Inst[15:11])
    localparam logic [4:0] c_REG_STATUS = 5'd12;
    localparam logic [4:0] c_REG_CAUSE  = 5'd13;
    localparam logic [4:0] c_REG_EPC    = 5'd14;

    // Cause.ExcCode values
    localparam logic [4:0] c_EXC_INT = 5'd0;
    localparam logic [4:0] c_EXC_SYS = 5'd8;
    localparam logic [4:0] c_EXC_RI  = 5'd10;
    localparam logic [4:0] c_EXC_OV  = 5'd12;

    // Status bit positions
    localparam int c_ST_IE     = 0;
    localparam int c_ST_SYS_EN = 1;
    localparam int c_ST_RI_EN  = 2;
    localparam int c_ST_OV_EN  = 3;
    localparam int c_ST_EXL    = 4;

    // Cause bit position of the registered interrupt request
    localparam int c_CAUSE_IP = 8;

    // Instruction encodings
    localparam logic [10:0] c_OP_MFC0    = 11'h200;
    localparam logic [10:0] c_OP_MTC0    = 11'h204;
    localparam logic [31:0] c_INST_ERET  = 32'h4200_0018;
    localparam logic [5:0]  c_OP_SPECIAL = 6'h00;
    localparam logic [5:0]  c_FN_SYSCALL = 6'h0C;

    // FSM state encoding; the state value doubles as Status.EXL
    localparam logic [0:0] c_STATE_NORMAL  = 1'b0;
    localparam logic [0:0] c_STATE_HANDLER = 1'b1;

endpackage : cp0_pkg
`default_nettype wire

// File: rtl/cp0_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_decode
//  Description : Combinational decode of the fetched instruction word into
//                the CP0-relevant instruction classes and register select.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_decode (
    input  logic [31:0] i_inst,
    output logic        o_is_mfc0,
    output logic        o_is_mtc0,
    output logic        o_is_eret,
    output logic        o_is_sys,
    output logic [4:0]  o_regsel
);
    import cp0_pkg::*;

    assign o_is_mfc0 = (i_inst[31:21] == c_OP_MFC0);
    assign o_is_mtc0 = (i_inst[31:21] == c_OP_MTC0);
    assign o_is_eret = (i_inst == c_INST_ERET);
    assign o_is_sys  = (i_inst[31:26] == c_OP_SPECIAL) && (i_inst[5:0] == c_FN_SYSCALL);
    assign o_regsel  = i_inst[15:11];

endmodule : cp0_decode
`default_nettype wire

// File: rtl/cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_exc_unit
//  Description : Coprocessor-0 and exception unit for the single-cycle MIPS
//                core. Holds Status/Cause/EPC, detects RI/Sys/Ov/Int, drives
//                the PC redirect and squashes the faulting instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_exc_unit #(
    parameter logic [31:0] VECTOR     = 32'h0000_0040,
    parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Inst,
    input  logic [31:0] PC,
    input  logic        Ri,
    input  logic        Ovf,
    input  logic        IntReq,
    input  logic [31:0] Rt_data,
    output logic [31:0] Cp0_rdata,
    output logic        Redirect,
    output logic [31:0] Redirect_pc,
    output logic        Squash,
    output logic [31:0] Status,
    output logic [31:0] Cause,
    output logic [31:0] EPC
);
    import cp0_pkg::*;

    logic        w_is_mfc0;
    logic        w_is_mtc0;
    logic        w_is_eret;
    logic        w_is_sys;
    logic [4:0]  w_regsel;

    logic [0:0]  r_state;
    logic [31:5] r_status_hi;   // Status bit 4 is the FSM state, not stored
    logic [3:0]  r_status_lo;
    logic [4:0]  r_exc_code;
    logic        r_ip;
    logic [31:0] r_epc;

    logic        w_take;
    logic [4:0]  w_code;

    cp0_decode u_decode (
        .i_inst    (Inst),
        .o_is_mfc0 (w_is_mfc0),
        .o_is_mtc0 (w_is_mtc0),
        .o_is_eret (w_is_eret),
        .o_is_sys  (w_is_sys),
        .o_regsel  (w_regsel)
    );

    assign Status = {r_status_hi, (r_state == c_STATE_HANDLER), r_status_lo};
    assign Cause  = {23'd0, r_ip, 1'b0, r_exc_code, 2'b00};
    assign EPC    = r_epc;

    // Prioritised exception take; only in NORMAL and never on eret or reset
    always_comb begin
        w_take = 1'b0;
        w_code = c_EXC_INT;
        if (!Reset && !w_is_eret && (r_state == c_STATE_NORMAL)) begin
            if (Ri && Status[c_ST_RI_EN]) begin
                w_take = 1'b1;
                w_code = c_EXC_RI;
            end else if (w_is_sys && Status[c_ST_SYS_EN]) begin
                w_take = 1'b1;
                w_code = c_EXC_SYS;
            end else if (Ovf && Status[c_ST_OV_EN]) begin
                w_take = 1'b1;
                w_code = c_EXC_OV;
            end else if (Cause[c_CAUSE_IP] && Status[c_ST_IE]) begin
                w_take = 1'b1;
                w_code = c_EXC_INT;
            end
        end
    end

    assign Squash      = w_take;
    assign Redirect    = w_take | (w_is_eret & ~Reset);
    assign Redirect_pc = w_is_eret ? r_epc : VECTOR;

    // mfc0 read mux: pre-edge register values, zero for non-mfc0
    always_comb begin
        Cp0_rdata = 32'd0;
        if (w_is_mfc0) begin
            case (w_regsel)
                c_REG_STATUS: Cp0_rdata = Status;
                c_REG_CAUSE:  Cp0_rdata = Cause;
                c_REG_EPC:    Cp0_rdata = EPC;
                default:      Cp0_rdata = 32'd0;
            endcase
        end
    end

    // Exception FSM plus CP0 register updates; take beats eret beats mtc0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= c_STATE_NORMAL;
            r_status_hi <= STATUS_RST[31:5];
            r_status_lo <= STATUS_RST[3:0];
            r_exc_code  <= 5'd0;
            r_ip        <= 1'b0;
            r_epc       <= 32'd0;
        end else begin
            r_ip <= IntReq;
            if (w_take) begin
                r_state    <= c_STATE_HANDLER;
                r_epc      <= PC;
                r_exc_code <= w_code;
            end else if (w_is_eret) begin
                r_state <= c_STATE_NORMAL;
            end else if (w_is_mtc0) begin
                case (w_regsel)
                    c_REG_STATUS: begin
                        r_status_hi <= Rt_data[31:5];
                        r_status_lo <= Rt_data[3:0];
                    end
                    c_REG_CAUSE:  r_exc_code <= Rt_data[6:2];
                    c_REG_EPC:    r_epc      <= Rt_data;
                    default:      ;
                endcase
            end
        end
    end

endmodule : cp0_exc_unit
`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_exc_unit
//  Description : Self-checking bench for cp0_exc_unit: directed scenarios
//                followed by randomized instruction streams, all compared
//                against a behavioural CP0 model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exc_unit;

    localparam logic [31:0] c_VEC  = 32'h0000_0040;
    localparam logic [31:0] c_SRST = 32'h0000_0000;
    localparam logic [31:0] c_ERET = 32'h4200_0018;
    localparam logic [31:0] c_SYSC = 32'h0000_000C;
    localparam logic [31:0] c_ADD  = 32'h0109_5020;
    localparam logic [31:0] c_NOP  = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Inst;
    logic [31:0] PC;
    logic        Ri;
    logic        Ovf;
    logic        IntReq;
    logic [31:0] Rt_data;
    logic [31:0] Cp0_rdata;
    logic        Redirect;
    logic [31:0] Redirect_pc;
    logic        Squash;
    logic [31:0] Status;
    logic [31:0] Cause;
    logic [31:0] EPC;

    cp0_exc_unit #(
        .VECTOR     (c_VEC),
        .STATUS_RST (c_SRST)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Inst        (Inst),
        .PC          (PC),
        .Ri          (Ri),
        .Ovf         (Ovf),
        .IntReq      (IntReq),
        .Rt_data     (Rt_data),
        .Cp0_rdata   (Cp0_rdata),
        .Redirect    (Redirect),
        .Redirect_pc (Redirect_pc),
        .Squash      (Squash),
        .Status      (Status),
        .Cause       (Cause),
        .EPC         (EPC)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: architectural view of CP0
    logic [31:0] m_status = 32'd0;   // bit 4 kept at 0, EXL tracked separately
    logic        m_exl    = 1'b0;
    logic [4:0]  m_code   = 5'd0;
    logic        m_ip     = 1'b0;
    logic [31:0] m_epc    = 32'd0;

    // Combinational outputs captured mid-cycle by run_cycle
    logic        cap_redirect;
    logic        cap_squash;
    logic [31:0] cap_rpc;
    logic [31:0] cap_rdata;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_mtc0(input logic [4:0] sel);
        return {11'h204, 5'd8, sel, 11'd0};
    endfunction

    function automatic logic [31:0] mk_mfc0(input logic [4:0] sel);
        return {11'h200, 5'd8, sel, 11'd0};
    endfunction

    function automatic logic [31:0] m_status_val();
        return m_status | (m_exl ? 32'h10 : 32'h0);
    endfunction

    function automatic logic [31:0] m_cause_val();
        return (32'(m_ip) << 8) | (32'(m_code) << 2);
    endfunction

    function automatic logic [31:0] m_read(input int sel);
        if (sel == 12) return m_status_val();
        if (sel == 13) return m_cause_val();
        if (sel == 14) return m_epc;
        return 32'd0;
    endfunction

    // One instruction: drive, check combinational outputs, clock, check registers
    task automatic run_cycle(input logic [31:0] inst, input logic [31:0] pc,
                             input logic ri, input logic ovf, input logic irq,
                             input logic [31:0] rt, input logic rst);
        bit is_mf, is_mt, is_er, is_sy;
        int sel;
        int code;
        bit exp_redir;
        @(negedge Clk);
        Inst = inst; PC = pc; Ri = ri; Ovf = ovf; IntReq = irq; Rt_data = rt; Reset = rst;
        #1;
        is_mf = (inst[31:21] == 11'h200);
        is_mt = (inst[31:21] == 11'h204);
        is_er = (inst == c_ERET);
        is_sy = (inst[31:26] == 6'd0) && (inst[5:0] == 6'h0C);
        sel   = int'(inst[15:11]);
        code  = -1;
        if (!rst && !is_er && !m_exl) begin
            if (ri && m_status[2])       code = 10;
            else if (is_sy && m_status[1]) code = 8;
            else if (ovf && m_status[3])   code = 12;
            else if (m_ip && m_status[0])  code = 0;
        end
        exp_redir = !rst && (is_er || code >= 0);
        cap_redirect = Redirect;
        cap_squash   = Squash;
        cap_rpc      = Redirect_pc;
        cap_rdata    = Cp0_rdata;
        check32("redirect", 32'(Redirect), 32'(exp_redir));
        check32("squash", 32'(Squash), 32'(code >= 0));
        check32("rdata", Cp0_rdata, is_mf ? m_read(sel) : 32'd0);
        if (exp_redir) check32("redirect_pc", Redirect_pc, is_er ? m_epc : c_VEC);
        @(posedge Clk);
        if (rst) begin
            m_status = c_SRST & ~32'h10;
            m_exl = 1'b0; m_code = 5'd0; m_ip = 1'b0; m_epc = 32'd0;
        end else begin
            m_ip = irq;
            if (code >= 0) begin
                m_epc = pc; m_code = 5'(code); m_exl = 1'b1;
            end else if (is_er) begin
                m_exl = 1'b0;
            end else if (is_mt) begin
                if (sel == 12)      m_status = rt & ~32'h10;
                else if (sel == 13) m_code   = rt[6:2];
                else if (sel == 14) m_epc    = rt;
            end
        end
        #1;
        check32("status", Status, m_status_val());
        check32("cause", Cause, m_cause_val());
        check32("epc", EPC, m_epc);
    endtask

    // Directed scenarios, then randomized streams
    initial begin
        logic [31:0] inst, pc, rt;
        logic ri, ovf, rst, irq;
        int r;
        Reset = 1'b1; Inst = c_NOP; PC = 32'd0; Ri = 1'b0; Ovf = 1'b0;
        IntReq = 1'b0; Rt_data = 32'd0;

        run_cycle(c_NOP, 32'h0, 0, 0, 0, 32'h0, 1);
        run_cycle(c_SYSC, 32'h0, 0, 0, 0, 32'h0, 1);
        check32("rst_status", Status, 32'h0);
        check32("rst_cause", Cause, 32'h0);
        check32("rst_epc", EPC, 32'h0);

        // Status write and read-back
        run_cycle(mk_mtc0(5'd12), 32'h04, 0, 0, 0, 32'hF, 0);
        run_cycle(mk_mfc0(5'd12), 32'h08, 0, 0, 0, 32'h0, 0);
        check32("t1_rdata", cap_rdata, 32'h0000_000F);

        // Overflow trap
        run_cycle(c_ADD, 32'h10, 0, 1, 0, 32'h0, 0);
        check32("t2_redirect", 32'(cap_redirect), 32'd1);
        check32("t2_rpc", cap_rpc, 32'h40);
        check32("t2_squash", 32'(cap_squash), 32'd1);
        check32("t2_epc", EPC, 32'h10);
        check32("t2_code", 32'(Cause[6:2]), 32'd12);
        check32("t2_exl", 32'(Status[4]), 32'd1);

        // No nesting in the handler; mtc0 EPC then eret
        run_cycle(c_ADD, 32'h40, 0, 1, 0, 32'h0, 0);
        check32("t3_no_nest_ov", 32'(cap_redirect), 32'd0);
        run_cycle(c_SYSC, 32'h44, 0, 0, 0, 32'h0, 0);
        check32("t3_no_nest_sys", 32'(cap_redirect), 32'd0);
        run_cycle(mk_mtc0(5'd14), 32'h48, 0, 0, 0, 32'h14, 0);
        run_cycle(c_ERET, 32'h4C, 0, 0, 0, 32'h0, 0);
        check32("t3_eret_pc", cap_rpc, 32'h14);
        check32("t3_eret_squash", 32'(cap_squash), 32'd0);
        check32("t3_exl", 32'(Status[4]), 32'd0);

        // Syscall taken, then masked
        run_cycle(c_SYSC, 32'h2C, 0, 0, 0, 32'h0, 0);
        check32("t4_epc", EPC, 32'h2C);
        check32("t4_code", 32'(Cause[6:2]), 32'd8);
        run_cycle(c_ERET, 32'h40, 0, 0, 0, 32'h0, 0);
        run_cycle(mk_mtc0(5'd12), 32'h30, 0, 0, 0, 32'hD, 0);
        run_cycle(c_SYSC, 32'h2C, 0, 0, 0, 32'h0, 0);
        check32("t4_masked_redirect", 32'(cap_redirect), 32'd0);
        check32("t4_masked_status", Status, 32'hD);
        check32("t4_masked_cause", Cause, 32'd8 << 2);

        // RI beats Ov; then Int beats mtc0
        run_cycle(mk_mtc0(5'd12), 32'h30, 0, 0, 0, 32'hF, 0);
        run_cycle(c_ADD, 32'h34, 1, 1, 0, 32'h0, 0);
        check32("t5_code_ri", 32'(Cause[6:2]), 32'd10);
        run_cycle(c_ERET, 32'h40, 0, 0, 0, 32'h0, 0);
        run_cycle(c_NOP, 32'h38, 0, 0, 1, 32'h0, 0);
        run_cycle(mk_mtc0(5'd12), 32'h3C, 0, 0, 1, 32'h0, 0);
        check32("t5_int_taken", 32'(cap_squash), 32'd1);
        check32("t5_code_int", 32'(Cause[6:2]), 32'd0);
        check32("t5_status_kept", Status, 32'h1F);
        run_cycle(c_ERET, 32'h40, 0, 0, 0, 32'h0, 0);

        // Reset mid-handler
        run_cycle(c_SYSC, 32'h2C, 0, 0, 0, 32'h0, 0);
        check32("t6_pre_epc", EPC, 32'h2C);
        run_cycle(c_SYSC, 32'h30, 1, 1, 1, 32'h0, 1);
        check32("t6_redirect", 32'(cap_redirect), 32'd0);
        check32("t6_status", Status, 32'h0);
        check32("t6_cause", Cause, 32'h0);
        check32("t6_epc", EPC, 32'h0);

        // Randomized instruction mix with random enables, interrupts and resets
        irq = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = int'($urandom_range(0, 99));
            rt = $urandom;
            if (r < 15)      inst = mk_mfc0(5'($urandom_range(11, 15)));
            else if (r < 35) inst = mk_mtc0(5'($urandom_range(11, 15)));
            else if (r < 42) inst = c_ERET;
            else if (r < 55) inst = c_SYSC;
            else             inst = $urandom;
            pc  = $urandom & 32'hFFFF_FFFC;
            ri  = ($urandom_range(0, 9) == 0);
            ovf = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) irq = ~irq;
            rst = ($urandom_range(0, 149) == 0);
            run_cycle(inst, pc, ri, ovf, irq, rt, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cp0_exc_unit
`default_nettype wire
